// File: rtl/seq_alu_pkg.sv
// Shared op-codes and FSM state type for the multi-cycle ALU.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_PASS = 5'h02;
    localparam logic [4:0] OP_NOT  = 5'h03;
    localparam logic [4:0] OP_AND  = 5'h04;
    localparam logic [4:0] OP_OR   = 5'h05;
    localparam logic [4:0] OP_NAND = 5'h06;
    localparam logic [4:0] OP_NOR  = 5'h07;
    localparam logic [4:0] OP_XOR  = 5'h08;
    localparam logic [4:0] OP_XNOR = 5'h09;
    localparam logic [4:0] OP_SLL  = 5'h0A;
    localparam logic [4:0] OP_SRL  = 5'h0B;
    localparam logic [4:0] OP_SLA  = 5'h0C;
    localparam logic [4:0] OP_SRA  = 5'h0D;
    localparam logic [4:0] OP_NEG  = 5'h0E;
    localparam logic [4:0] OP_ZERO = 5'h0F;
    localparam logic [4:0] OP_MUL  = 5'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_comb_core.sv
// Combinational datapath for the sixteen single-cycle functions.
module alu_comb_core
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [3:0]            func,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int MSB         = DATA_WIDTH - 1;

    logic [SHAMT_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0]  diff;

    assign sh   = b[SHAMT_WIDTH-1:0];
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (func)
            OP_ADD[3:0]: begin
                result   = sum;
                overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB[3:0]: begin
                result   = diff;
                overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_PASS[3:0]: result = a;
            OP_NOT[3:0]:  result = ~a;
            OP_AND[3:0]:  result = a & b;
            OP_OR[3:0]:   result = a | b;
            OP_NAND[3:0]: result = ~(a & b);
            OP_NOR[3:0]:  result = ~(a | b);
            OP_XOR[3:0]:  result = a ^ b;
            OP_XNOR[3:0]: result = ~(a ^ b);
            OP_SLL[3:0]:  result = a << sh;
            OP_SRL[3:0]:  result = a >> sh;
            OP_SLA[3:0]:  result = a << sh;
            OP_SRA[3:0]:  result = $signed(a) >>> sh;
            OP_NEG[3:0]:  result = -a;
            OP_ZERO[3:0]: result = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: handshake FSM, registered results, and shift-add unsigned multiply.
// state | meaning
// IDLE  | no result held, ready for a new op
// MUL   | shift-add multiply in progress, input stalled
// HOLD  | result valid, waiting for out_ready
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  overflow_flag,
    output logic                  zero_flag,
    output logic                  neg_flag
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;
    logic [W-1:0]    result_hi_q, result_hi_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;

    logic [W-1:0]    core_result;
    logic            core_ovf;
    logic            accept;
    logic [W:0]      step_sum;
    logic [2*W-1:0]  acc_step;

    alu_comb_core #(.DATA_WIDTH(W)) u_core (
        .func     (op[3:0]),
        .a        (a),
        .b        (b),
        .result   (core_result),
        .overflow (core_ovf)
    );

    assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign accept   = in_valid & in_ready;

    // Low half of acc starts as the multiplier and is consumed LSB-first as the product shifts in.
    assign step_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : {W{1'b0}})};
    assign acc_step = {step_sum, acc_q[W-1:1]};

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        neg_d       = neg_q;

        case (state_q)
            MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = HOLD;
                    result_d    = acc_step[W-1:0];
                    result_hi_d = acc_step[2*W-1:W];
                    ovf_d       = |acc_step[2*W-1:W];
                    zero_d      = (acc_step == '0);
                    neg_d       = acc_step[W-1];
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            if (op == OP_MUL) begin
                state_d = MUL;
                mcand_d = a;
                acc_d   = {{W{1'b0}}, b};
                cnt_d   = CW'(W);
            end else begin
                state_d     = HOLD;
                result_hi_d = '0;
                if (!op[4]) begin
                    result_d = core_result;
                    ovf_d    = core_ovf;
                    zero_d   = (core_result == '0);
                    neg_d    = core_result[W-1];
                end else begin
                    // Reserved extended codes report all-zero result and all-zero flags.
                    result_d = '0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    neg_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end

    assign out_valid     = (state_q == HOLD);
    assign result        = result_q;
    assign result_hi     = result_hi_q;
    assign overflow_flag = ovf_q;
    assign zero_flag     = zero_q;
    assign neg_flag      = neg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner cases plus randomized traffic against a behavioural model.
module tb_seq_alu;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    op = 5'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          overflow_flag;
    logic          zero_flag;
    logic          neg_flag;

    always #5 clk = ~clk;

    seq_alu #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .result_hi     (result_hi),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    // Reference results from plain integer arithmetic.
    function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int          sx, sy, s;
        int unsigned sh;
        logic [31:0] p;
        e  = '0;
        sx = $signed(x);
        sy = $signed(y);
        sh = y[3:0];
        if (o[4]) begin
            if (o == 5'h10) begin
                p    = 32'(x) * 32'(y);
                e.r  = p[15:0];
                e.hi = p[31:16];
                e.v  = (p >= 32'h10000);
                e.z  = (p == 0);
                e.n  = p[15];
            end
            return e;
        end
        case (o[3:0])
            4'd0:  begin s = sx + sy; e.r = 16'(s); e.v = (s > 32767) || (s < -32768); end
            4'd1:  begin s = sx - sy; e.r = 16'(s); e.v = (s > 32767) || (s < -32768); end
            4'd2:  e.r = x;
            4'd3:  e.r = ~x;
            4'd4:  e.r = x & y;
            4'd5:  e.r = x | y;
            4'd6:  e.r = ~(x & y);
            4'd7:  e.r = ~(x | y);
            4'd8:  e.r = x ^ y;
            4'd9:  e.r = ~(x ^ y);
            4'd10, 4'd12: e.r = 16'(32'(x) * (32'd1 << sh));
            4'd11: e.r = 16'(32'(x) / (32'd1 << sh));
            4'd13: e.r = 16'(sx >>> sh);
            4'd14: e.r = 16'(-sx);
            default: e.r = '0;
        endcase
        e.z = (e.r == 0);
        e.n = e.r[15];
        return e;
    endfunction

    // Model of the handshake: at most one op in flight, ready to show after 'left' more edges.
    bit   have_op = 1'b0;
    int   left = 0;
    exp_t cur = '0;
    logic exp_ov, exp_ir;

    always @(negedge clk) begin
        if (reset) begin
            have_op = 1'b0;
            left    = 0;
        end else begin
            exp_ov = have_op && (left == 0);
            exp_ir = !have_op || ((left == 0) && out_ready);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_ir);
            if (exp_ov) begin
                chk("result", result, cur.r);
                chk("result_hi", result_hi, cur.hi);
                chk("overflow", overflow_flag, cur.v);
                chk("zero", zero_flag, cur.z);
                chk("neg", neg_flag, cur.n);
            end
            if (exp_ov && out_ready) have_op = 1'b0;
            if (have_op && left > 0) left--;
            if (in_valid && exp_ir) begin
                have_op = 1'b1;
                cur     = model(op, a, b);
                left    = (op == 5'h10) ? W : 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        chk("issue_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        op = 5'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_result_hi", result_hi, 0);
        chk("rst_flags", {overflow_flag, zero_flag, neg_flag}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();

        in_valid = 1'b1; op = 5'h00; a = 16'h7FFF; b = 16'h0001;
        #1 chk("add_pre_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_res", result, 16'h8000);
        chk("add_flags", {overflow_flag, zero_flag, neg_flag}, 3'b101);
        step();

        issue(5'h01, 16'h8000, 16'h0001);
        chk("sub_res", result, 16'h7FFF);
        chk("sub_ovf", overflow_flag, 1);
        step();
        issue(5'h01, 16'h0005, 16'h0005);
        chk("sub0_res", result, 16'h0000);
        chk("sub0_flags", {overflow_flag, zero_flag}, 2'b01);
        step();
        issue(5'h0D, 16'h8004, 16'h0002);
        chk("sra_res", result, 16'hE001);
        step();
        issue(5'h0B, 16'h8004, 16'h0002);
        chk("srl_res", result, 16'h2001);
        step();
        issue(5'h0A, 16'h0001, 16'h001F);
        chk("sll_res", result, 16'h8000);
        step();

        issue(5'h10, 16'h0100, 16'h0100);
        n = 0;
        while (!out_valid && n < 40) begin
            chk("mul_busy_ready", in_ready, 0);
            step();
            n++;
        end
        chk("mul_latency", n, 16);
        chk("mul_res", result, 16'h0000);
        chk("mul_hi", result_hi, 16'h0001);
        chk("mul_flags", {overflow_flag, zero_flag}, 2'b10);
        step();

        out_ready = 1'b0;
        issue(5'h00, 16'h1234, 16'h1111);
        in_valid = 1'b1; op = 5'h00; a = 16'h0001; b = 16'h0002;
        repeat (5) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", result, 16'h2345);
            step();
        end
        out_ready = 1'b1;
        #1 chk("bp_ready_comb", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_res", result, 16'h0003);
        step();

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = 5'h00; a = 16'(i * 3); b = 16'd100;
            step();
        end
        in_valid = 1'b0;
        n = 8;
        while (out_valid && n < 30) begin
            step();
            n++;
        end
        chk("b2b_cycles", n, 9);

        issue(5'h10, 16'h0003, 16'h0005);
        repeat (8) step();
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", in_ready, 1);
        step();
        reset = 1'b0;
        step();
        issue(5'h00, 16'h0003, 16'h0004);
        chk("post_rst_add", result, 16'h0007);
        step();

        repeat (3000) begin
            r = $urandom_range(0, 19);
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = (r < 16) ? 5'(r) : (r < 18) ? 5'h10 : 5'($urandom_range(17, 31));
            a         = 16'($urandom);
            b         = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
